// File: rtl/rtmq_output_sr_buf_pkg.sv
// rtmq_output_sr_buf_pkg: shared RTMQ peripheral widths, ALU bus layout and control bit indices
package rtmq_output_sr_buf_pkg;
   localparam int W_REG = 32;
   localparam int W_ADR = 8;
   localparam int CTL_DIR  = 0;
   localparam int CTL_AUTO = 1;
   localparam int CTL_CMT  = 2;
   localparam int CTL_CLR  = 3;
   // One register write slot; the ALU bus carries two, so a push and a
   // control write can land on the same edge.
   typedef struct packed {
      logic             wen;
      logic [W_ADR-1:0] adr;
      logic [W_REG-1:0] dat;
   } alu_lane_t;
   typedef struct packed {
      alu_lane_t l1;
      alu_lane_t l0;
   } alu_bus_t;
   localparam int W_ALU = $bits(alu_bus_t);
   function automatic int osr_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/rtmq_output_sr_buf_if.sv
// rtmq_output_sr_buf_if: ALU bus input and committed-data outputs of the output shift register buffer
//   alu_out : ALU output bus (master drives)
//   dat_out : committed parallel data, dat_stb : commit strobe
//   wrd_cnt : words pushed since last commit/clear, ovf : sticky overflow
interface rtmq_output_sr_buf_if
   import rtmq_output_sr_buf_pkg::*;
#(
   parameter int N_SRL = 6
);
   localparam int W_OSR = W_REG * N_SRL;
   localparam int W_CNT = osr_cnt_w(N_SRL);
   logic [W_ALU-1:0] alu_out;
   logic [W_OSR-1:0] dat_out;
   logic             dat_stb;
   logic [W_CNT-1:0] wrd_cnt;
   logic             ovf;
   modport master (output alu_out, input dat_out, dat_stb, wrd_cnt, ovf);
   modport slave  (input alu_out, output dat_out, dat_stb, wrd_cnt, ovf);
endinterface

// File: rtl/RTMQ_GPRegister.sv
// RTMQ_GPRegister: general-purpose register decoding one address on the ALU bus
//   alu_out : ALU bus, trg : write hit this cycle
//   dat     : written value, passed straight through in the write cycle
module RTMQ_GPRegister
   import rtmq_output_sr_buf_pkg::*;
#(
   parameter int               ADDR    = 0,
   parameter logic [W_REG-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W_ALU-1:0] alu_out,
   output logic             trg,
   output logic [W_REG-1:0] dat
);
   alu_bus_t         bus;
   logic             hit0, hit1;
   logic [W_REG-1:0] dat_q, dat_d;
   always_comb begin
      bus   = alu_bus_t'(alu_out);
      hit0  = bus.l0.wen && bus.l0.adr == W_ADR'(ADDR);
      hit1  = bus.l1.wen && bus.l1.adr == W_ADR'(ADDR);
      trg   = hit0 || hit1;
      // both slots hitting the same address: the higher slot wins
      dat_d = hit1 ? bus.l1.dat : hit0 ? bus.l0.dat : dat_q;
      dat   = dat_d;
   end
   always_ff @(posedge clk) begin
      if (rst) dat_q <= RST_VAL;
      else     dat_q <= dat_d;
   end
endmodule

// File: rtl/rtmq_osr_core.sv
// rtmq_osr_core: shadow shift register, word counter, commit and overflow logic
//   push/push_dat : shift a word in, dir selects end (0: MSBs, 1: LSBs)
//   auto          : commit once N_SRL words have been pushed
//   commit/clear  : explicit commit / clear strobes (clear wins)
//   dat_out, dat_stb, wrd_cnt, ovf : committed data and status
module rtmq_osr_core
   import rtmq_output_sr_buf_pkg::*;
#(
   parameter int N_SRL = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [W_REG-1:0]             push_dat,
   input  logic                         dir,
   input  logic                         auto,
   input  logic                         commit,
   input  logic                         clear,
   output logic [W_REG*N_SRL-1:0]       dat_out,
   output logic                         dat_stb,
   output logic [osr_cnt_w(N_SRL)-1:0]  wrd_cnt,
   output logic                         ovf
);
   localparam int W_OSR = W_REG * N_SRL;
   localparam int W_CNT = osr_cnt_w(N_SRL);
   localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(N_SRL);
   logic [W_OSR-1:0] sh_q, sh_d, out_q, out_d, sh_psh;
   logic [W_CNT-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d, stb_q, stb_d, full, cmt;
   always_comb begin
      sh_psh = !push ? sh_q :
               dir   ? {sh_q[W_OSR-W_REG-1:0], push_dat} :
                       {push_dat, sh_q[W_OSR-1:W_REG]};
      full   = cnt_q == CNT_MAX;
      // auto commit fires on the push that brings the count to N_SRL
      cmt    = commit || (auto && push && cnt_q >= CNT_MAX - 1'b1);
      sh_d   = clear ? '0 : sh_psh;
      // committed data includes a push landing on the same edge
      out_d  = (cmt && !clear) ? sh_psh : out_q;
      cnt_d  = (clear || cmt) ? '0 : (push && !full) ? cnt_q + 1'b1 : cnt_q;
      ovf_d  = !clear && (ovf_q || (push && full));
      stb_d  = cmt && !clear;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         out_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         stb_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         out_q <= out_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         stb_q <= stb_d;
      end
   end
   assign dat_out = out_q;
   assign dat_stb = stb_q;
   assign wrd_cnt = cnt_q;
   assign ovf     = ovf_q;
endmodule

// File: rtl/rtmq_output_sr_buf.sv
// rtmq_output_sr_buf: double-buffered output shift register on the RTMQ ALU bus
//   clk, rst : clock, synchronous active-high reset
//   bus      : ALU bus in; dat_out/dat_stb/wrd_cnt/ovf out
//   ADDR pushes a word; ADDR_CTL takes {clear, commit, auto, dir} in bits [3:0]
module rtmq_output_sr_buf
   import rtmq_output_sr_buf_pkg::*;
#(
   parameter int ADDR     = 0,
   parameter int ADDR_CTL = 1,
   parameter int N_SRL    = 6,
   parameter bit DIR_DEF  = 1'b0,
   parameter bit AUTO_DEF = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   rtmq_output_sr_buf_if.slave bus
);
   if (N_SRL < 2 || ADDR == ADDR_CTL) begin : g_cfg_err
      $error("rtmq_output_sr_buf: N_SRL must be >= 2 and ADDR must differ from ADDR_CTL");
   end
   logic             psh_trg, ctl_trg;
   logic [W_REG-1:0] psh_dat, ctl_dat;
   logic             dir_q, dir_d, auto_q, auto_d;
   logic             unused_ctl;
   RTMQ_GPRegister #(.ADDR(ADDR)) u_dat (
      .clk     (clk),
      .rst     (rst),
      .alu_out (bus.alu_out),
      .trg     (psh_trg),
      .dat     (psh_dat)
   );
   RTMQ_GPRegister #(.ADDR(ADDR_CTL), .RST_VAL(W_REG'({AUTO_DEF, DIR_DEF}))) u_ctl (
      .clk     (clk),
      .rst     (rst),
      .alu_out (bus.alu_out),
      .trg     (ctl_trg),
      .dat     (ctl_dat)
   );
   // dir/auto are held here so a push on the write edge still sees the old values
   always_comb begin
      dir_d      = ctl_trg ? ctl_dat[CTL_DIR]  : dir_q;
      auto_d     = ctl_trg ? ctl_dat[CTL_AUTO] : auto_q;
      unused_ctl = ^ctl_dat[W_REG-1:CTL_CLR+1];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q  <= DIR_DEF;
         auto_q <= AUTO_DEF;
      end else begin
         dir_q  <= dir_d;
         auto_q <= auto_d;
      end
   end
   rtmq_osr_core #(.N_SRL(N_SRL)) u_core (
      .clk      (clk),
      .rst      (rst),
      .push     (psh_trg),
      .push_dat (psh_dat),
      .dir      (dir_q),
      .auto     (auto_q),
      .commit   (ctl_trg && ctl_dat[CTL_CMT]),
      .clear    (ctl_trg && ctl_dat[CTL_CLR]),
      .dat_out  (bus.dat_out),
      .dat_stb  (bus.dat_stb),
      .wrd_cnt  (bus.wrd_cnt),
      .ovf      (bus.ovf)
   );
endmodule
